// File: rtl/noc_replay_pkg.sv
// Shared types and helpers for the link-level replay buffer.
package noc_replay_pkg;

  typedef enum logic [1:0] {
    StStream,
    StReplay,
    StFail
  } replay_state_e;

  localparam int unsigned RetryCntW = 4;

  // True when seq lies in [lo, hi) on a circular sequence space of seq_w bits.
  function automatic logic seq_in_window(input logic [31:0] seq,
                                         input logic [31:0] lo,
                                         input logic [31:0] hi,
                                         input int unsigned seq_w);
    logic [31:0] mask;
    logic [31:0] off;
    logic [31:0] span;
    mask = (32'd1 << seq_w) - 32'd1;
    off  = (seq - lo) & mask;
    span = (hi - lo) & mask;
    return off < span;
  endfunction

endpackage

// File: rtl/noc_replay_ram.sv
// Flit storage: one synchronous write port, one asynchronous read port.
module noc_replay_ram #(
  parameter  int unsigned DATA_W = 64,
  parameter  int unsigned DEPTH  = 16,
  localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [PTR_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [PTR_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/noc_replay_buffer.sv
// Go-back-N replay buffer: holds every sent flit until cumulatively acked and
// rewinds to the oldest unacked flit on a rising edge of retry_req.
module noc_replay_buffer
  import noc_replay_pkg::*;
#(
  parameter  int unsigned DATA_W    = 64,
  parameter  int unsigned DEPTH     = 16,
  parameter  int unsigned MAX_RETRY = 3,
  localparam int unsigned PTR_W     = $clog2(DEPTH),
  localparam int unsigned SEQ_W     = PTR_W + 1
) (
  input  logic              clk_1p6ghz,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [SEQ_W-1:0]  out_seq,
  input  logic              out_ready,
  input  logic              ack_valid,
  input  logic [SEQ_W-1:0]  ack_seq,
  input  logic              retry_req,
  output logic              retry_busy,
  output logic              retry_fail,
  output logic [SEQ_W-1:0]  occupancy
);

  logic [SEQ_W-1:0]     head_q, head_d;
  logic [SEQ_W-1:0]     send_q, send_d;
  logic [SEQ_W-1:0]     tail_q, tail_d;
  logic [SEQ_W-1:0]     end_q, end_d;
  logic [RetryCntW-1:0] cnt_q, cnt_d;
  logic                 retry_q;
  replay_state_e        state_q, state_d;

  logic                 wr_en;
  logic                 tx_en;
  logic                 ack_ok;
  logic                 retry_ev;
  logic [SEQ_W-1:0]     send_post;
  logic [RetryCntW-1:0] cnt_post;

  assign occupancy  = tail_q - head_q;
  assign in_ready   = (occupancy != SEQ_W'(DEPTH));
  assign out_valid  = (send_q != tail_q) && (state_q != StFail);
  assign out_seq    = send_q;
  assign retry_busy = (state_q == StReplay);
  assign retry_fail = (state_q == StFail);

  assign wr_en    = in_valid & in_ready;
  assign tx_en    = out_valid & out_ready;
  assign retry_ev = retry_req & ~retry_q;
  assign ack_ok   = ack_valid &
                    seq_in_window(32'(ack_seq), 32'(head_q), 32'(send_q), SEQ_W);

  noc_replay_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk_i   (clk_1p6ghz),
    .we_i    (wr_en),
    .waddr_i (tail_q[PTR_W-1:0]),
    .wdata_i (in_data),
    .raddr_i (send_q[PTR_W-1:0]),
    .rdata_o (out_data)
  );

  always_comb begin
    tail_d    = tail_q;
    end_d     = end_q;
    state_d   = state_q;
    send_post = tx_en ? send_q + SEQ_W'(1) : send_q;
    head_d    = ack_ok ? ack_seq + SEQ_W'(1) : head_q;
    cnt_post  = ack_ok ? '0 : cnt_q;
    send_d    = send_post;
    cnt_d     = cnt_post;

    if (wr_en) begin
      tail_d = tail_q + SEQ_W'(1);
    end

    // Ack is folded in first so a rewind targets the post-ack head; a flit
    // handshaked on the retry edge counts as sent before being rewound.
    unique case (state_q)
      StStream: begin
        if (retry_ev) begin
          if (cnt_post == RetryCntW'(MAX_RETRY)) begin
            state_d = StFail;
          end else if (head_d != send_post) begin
            send_d  = head_d;
            end_d   = send_post;
            cnt_d   = cnt_post + RetryCntW'(1);
            state_d = StReplay;
          end
        end
      end
      StReplay: begin
        if (retry_ev && (cnt_post == RetryCntW'(MAX_RETRY))) begin
          state_d = StFail;
        end else if (retry_ev && (head_d != send_post)) begin
          send_d = head_d;
          cnt_d  = cnt_post + RetryCntW'(1);
        end else if (tx_en && (send_post == end_q)) begin
          state_d = StStream;
        end
      end
      StFail: begin
        state_d = StFail;
      end
      default: begin
        state_d = StStream;
      end
    endcase
  end

  always_ff @(posedge clk_1p6ghz) begin
    if (rst) begin
      head_q  <= '0;
      send_q  <= '0;
      tail_q  <= '0;
      end_q   <= '0;
      cnt_q   <= '0;
      retry_q <= 1'b0;
      state_q <= StStream;
    end else begin
      head_q  <= head_d;
      send_q  <= send_d;
      tail_q  <= tail_d;
      end_q   <= end_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_req;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_noc_replay_buffer.sv
// Directed bench for noc_replay_buffer: expected link flits are queued by the
// stimulus and popped by an independent monitor on every output handshake.
`timescale 1ns/1ps
module tb_noc_replay_buffer;

  localparam int unsigned DATA_W    = 64;
  localparam int unsigned DEPTH     = 16;
  localparam int unsigned MAX_RETRY = 3;
  localparam int unsigned SEQ_W     = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [SEQ_W-1:0]  out_seq;
  logic              out_ready;
  logic              ack_valid;
  logic [SEQ_W-1:0]  ack_seq;
  logic              retry_req;
  logic              retry_busy;
  logic              retry_fail;
  logic [SEQ_W-1:0]  occupancy;

  always #5 clk = ~clk;

  noc_replay_buffer #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .clk_1p6ghz (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_seq    (out_seq),
    .out_ready  (out_ready),
    .ack_valid  (ack_valid),
    .ack_seq    (ack_seq),
    .retry_req  (retry_req),
    .retry_busy (retry_busy),
    .retry_fail (retry_fail),
    .occupancy  (occupancy)
  );

  typedef struct packed {
    logic [SEQ_W-1:0]  seq;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic logic [DATA_W-1:0] flit(input int s);
    return 64'hA5A5_0000_0000_0000 | 64'(s);
  endfunction

  task automatic expect_seq(input int lo, input int hi);
    for (int s = lo; s <= hi; s++) exp_q.push_back({SEQ_W'(s), flit(s)});
  endtask

  // Scoreboard monitor: inputs change 1ns after posedge, so negedge sees the
  // values the DUT will sample at the next edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_flit: got seq %0d data %h, none expected", out_seq, out_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (out_seq !== mon_e.seq || out_data !== mon_e.data) begin
          miscompares++;
          $display("FAIL link_flit: got seq %0d data %h, want seq %0d data %h",
                   out_seq, out_data, mon_e.seq, mon_e.data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    ack_valid = 1'b0; ack_seq = '0; retry_req = 1'b0;
    tick(2);
    rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_retry_busy", 64'(retry_busy), 64'd0);
    check("rst_retry_fail", 64'(retry_fail), 64'd0);
  endtask

  task automatic write_n(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = flit(first + i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic ack(input int s);
    ack_valid = 1'b1;
    ack_seq   = SEQ_W'(s);
    tick();
    ack_valid = 1'b0;
  endtask

  initial begin
    // Basic streaming, out-of-window acks, cumulative ack.
    do_reset();
    out_ready = 1'b1;
    expect_seq(0, 3);
    write_n(0, 4);
    tick(3);
    check("stream_drained", 64'(out_valid), 64'd0);
    ack(9);
    check("ack_outside_ignored", 64'(occupancy), 64'd4);
    ack(4);
    check("ack_at_send_ignored", 64'(occupancy), 64'd4);
    ack(3);
    check("ack3_occupancy", 64'(occupancy), 64'd0);

    // Fill to DEPTH with the link stalled.
    do_reset();
    write_n(0, 16);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_occupancy", 64'(occupancy), 64'd16);
    check("full_out_seq", 64'(out_seq), 64'd0);
    in_valid = 1'b1;
    in_data  = flit(16);
    tick(2);
    in_valid = 1'b0;
    check("overfill_rejected", 64'(occupancy), 64'd16);
    expect_seq(0, 15);
    out_ready = 1'b1;
    tick(16);
    check("sent_all_out_valid", 64'(out_valid), 64'd0);
    check("sent_unacked_full", 64'(in_ready), 64'd0);
    ack(15);
    check("drain_occupancy", 64'(occupancy), 64'd0);
    check("drain_in_ready", 64'(in_ready), 64'd1);

    // Rewind to post-ack head after ack 2.
    do_reset();
    out_ready = 1'b1;
    expect_seq(0, 5);
    write_n(0, 6);
    tick(3);
    ack(2);
    check("ack2_occupancy", 64'(occupancy), 64'd3);
    expect_seq(3, 5);
    retry_req = 1'b1;
    tick();
    check("replay_first_seq", 64'(out_seq), 64'd3);
    check("replay_busy_3", 64'(retry_busy), 64'd1);
    tick();
    check("replay_busy_4", 64'(retry_busy), 64'd1);
    tick();
    check("replay_busy_5", 64'(retry_busy), 64'd1);
    tick();
    check("replay_done_busy", 64'(retry_busy), 64'd0);
    check("replay_done_valid", 64'(out_valid), 64'd0);
    retry_req = 1'b0;
    tick();

    // Same-cycle ack and retry.
    do_reset();
    out_ready = 1'b1;
    expect_seq(0, 3);
    write_n(0, 4);
    tick(3);
    expect_seq(2, 3);
    retry_req = 1'b1;
    ack(1);
    check("ackretry_seq", 64'(out_seq), 64'd2);
    check("ackretry_busy", 64'(retry_busy), 64'd1);
    check("ackretry_occupancy", 64'(occupancy), 64'd2);
    tick(2);
    check("ackretry_done", 64'(retry_busy), 64'd0);
    retry_req = 1'b0;
    tick();

    // Level held for 10 cycles gives a single rewind.
    do_reset();
    out_ready = 1'b1;
    expect_seq(0, 3);
    write_n(0, 4);
    tick(3);
    expect_seq(0, 3);
    retry_req = 1'b1;
    tick(10);
    check("hold_busy", 64'(retry_busy), 64'd0);
    check("hold_out_seq", 64'(out_seq), 64'd4);
    check("hold_fail", 64'(retry_fail), 64'd0);
    retry_req = 1'b0;
    tick();

    // Four retry edges without progress escalate to the sticky fail.
    do_reset();
    out_ready = 1'b1;
    expect_seq(0, 3);
    write_n(0, 4);
    tick(3);
    expect_seq(0, 1);
    expect_seq(0, 1);
    expect_seq(0, 1);
    retry_req = 1'b1; tick();
    retry_req = 1'b0; tick();
    retry_req = 1'b1; tick();
    retry_req = 1'b0; tick();
    retry_req = 1'b1; tick();
    check("edge3_busy", 64'(retry_busy), 64'd1);
    check("edge3_fail", 64'(retry_fail), 64'd0);
    retry_req = 1'b0; tick();
    retry_req = 1'b1; tick();
    check("edge4_fail", 64'(retry_fail), 64'd1);
    check("edge4_busy", 64'(retry_busy), 64'd0);
    check("edge4_out_valid", 64'(out_valid), 64'd0);
    retry_req = 1'b0;
    tick(2);
    check("fail_out_valid", 64'(out_valid), 64'd0);
    ack(1);
    check("fail_ack_retires", 64'(occupancy), 64'd2);
    check("fail_sticky", 64'(retry_fail), 64'd1);
    write_n(4, 1);
    check("fail_write_occupancy", 64'(occupancy), 64'd3);
    check("fail_write_out_valid", 64'(out_valid), 64'd0);
    do_reset();

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
